// File: rtl/maze_engine.sv
// Maze game engine: a fixed path of button presses leads through ROOMS rooms to a win, and wrong presses are counted.
// Drives its own multiplexed 4-digit display. The optional inactivity timeout is enabled by the MAZE_TIMEOUT_EN macro.
module maze_engine #(
    parameter int          ROOMS          = 8,
    parameter logic [29:0] PATH           = 30'h0,
    parameter logic [1:0]  ACTIVE_STATE   = 2'b10,
    parameter int          SCAN_DIV       = 50000,
    parameter int          TIMEOUT_CYCLES = 500000000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BTNL,
    input  logic       BTNC,
    input  logic       BTNR,
    input  logic [1:0] MASTER_STATE,
    output logic [3:0] SEG_SELECT,
    output logic [7:0] HEX_OUT,
    output logic [3:0] MazeSM_OUT,
    output logic       MAZE_DONE
);
    typedef enum logic {S_PLAY, S_WIN} state_t;

    localparam int          SW        = $clog2(SCAN_DIV);
    localparam logic [31:0] PATH_X    = {2'b11, PATH};
    localparam logic [3:0]  LAST_ROOM = 4'(ROOMS - 1);

    state_t        state_q, state_d;
    logic [3:0]    room_q, room_d;
    logic [7:0]    fail_q, fail_d;
    logic          done_q, done_d;
    logic          act_prev_q;
    logic [2:0]    btn_q, prev_q;
    logic [SW-1:0] scan_q, scan_d;
    logic [1:0]    digit_q, digit_d;
    logic [3:0]    seg_q, seg_d;
    logic [7:0]    hex_q, hex_d;
`ifdef MAZE_TIMEOUT_EN
    localparam logic [31:0] TMR_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0]   tmr_q, tmr_d;
`endif

    logic       active;
    logic [2:0] rise;
    logic [1:0] press_code, path_code;
    logic       hit, fail_inc;
    logic [3:0] nib;

    // Button bit index equals its path code: bit0 = L, bit1 = C, bit2 = R.
    assign active    = (MASTER_STATE == ACTIVE_STATE);
    assign rise      = btn_q & ~prev_q;
    assign path_code = PATH_X[{room_q, 1'b0} +: 2];

    always_comb begin
        case (rise)
            3'b001:  press_code = 2'b00;
            3'b010:  press_code = 2'b01;
            3'b100:  press_code = 2'b10;
            default: press_code = 2'b11;
        endcase
    end

    assign hit = $onehot(rise) && (path_code != 2'b11) && (press_code == path_code);

    always_comb begin
        state_d  = state_q;
        room_d   = room_q;
        done_d   = 1'b0;
        fail_inc = 1'b0;
`ifdef MAZE_TIMEOUT_EN
        tmr_d    = '0;
`endif
        if (active) begin
            if (state_q == S_WIN) begin
                if (!act_prev_q) begin
                    state_d = S_PLAY;
                    room_d  = '0;
                end
            end else if (|rise) begin
                if (hit) begin
                    if (room_q == LAST_ROOM) begin
                        state_d = S_WIN;
                        done_d  = 1'b1;
                    end else begin
                        room_d = room_q + 4'd1;
                    end
                end else begin
                    room_d   = '0;
                    fail_inc = 1'b1;
                end
            end
`ifdef MAZE_TIMEOUT_EN
            else if (room_q != 4'd0) begin
                if (tmr_q == TMR_LAST) begin
                    room_d   = '0;
                    fail_inc = 1'b1;
                end else begin
                    tmr_d = tmr_q + 32'd1;
                end
            end
`endif
        end
        fail_d = (fail_inc && fail_q != 8'hFF) ? fail_q + 8'd1 : fail_q;
    end

    function automatic logic [7:0] font(input logic [3:0] v);
        case (v)
            4'h0: font = 8'hC0;  4'h1: font = 8'hF9;  4'h2: font = 8'hA4;  4'h3: font = 8'hB0;
            4'h4: font = 8'h99;  4'h5: font = 8'h92;  4'h6: font = 8'h82;  4'h7: font = 8'hF8;
            4'h8: font = 8'h80;  4'h9: font = 8'h90;  4'hA: font = 8'h88;  4'hB: font = 8'h83;
            4'hC: font = 8'hC6;  4'hD: font = 8'hA1;  4'hE: font = 8'h86;  default: font = 8'h8E;
        endcase
    endfunction

    // Display content follows the next-state values so digits never lag the game by a cycle.
    always_comb begin
        scan_d  = scan_q + SW'(1);
        digit_d = digit_q;
        if (scan_q == SW'(SCAN_DIV - 1)) begin
            scan_d  = '0;
            digit_d = digit_q + 2'd1;
        end
        case (digit_d)
            2'd0:    nib = (state_d == S_WIN) ? 4'hF : room_d;
            2'd1:    nib = fail_d[3:0];
            2'd2:    nib = fail_d[7:4];
            default: nib = (state_d == S_WIN) ? 4'hF : (active ? 4'hA : 4'h0);
        endcase
        seg_d = ~(4'b0001 << digit_d);
        hex_d = font(nib);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_PLAY;
            room_q     <= '0;
            fail_q     <= '0;
            done_q     <= 1'b0;
            act_prev_q <= 1'b0;
            btn_q      <= '0;
            prev_q     <= '0;
            scan_q     <= '0;
            digit_q    <= '0;
            seg_q      <= 4'b1110;
            hex_q      <= 8'hC0;
        end else begin
            state_q    <= state_d;
            room_q     <= room_d;
            fail_q     <= fail_d;
            done_q     <= done_d;
            act_prev_q <= active;
            btn_q      <= {BTNR, BTNC, BTNL};
            prev_q     <= btn_q;
            scan_q     <= scan_d;
            digit_q    <= digit_d;
            seg_q      <= seg_d;
            hex_q      <= hex_d;
        end
    end

`ifdef MAZE_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (RESET) tmr_q <= '0;
        else       tmr_q <= tmr_d;
    end
`endif

    assign SEG_SELECT = seg_q;
    assign HEX_OUT    = hex_q;
    assign MazeSM_OUT = (state_q == S_WIN) ? 4'hF : room_q;
    assign MAZE_DONE  = done_q;
endmodule

// File: tb/tb_maze_engine.sv
// Bench for maze_engine: 3-room maze (L, C, R) with a fast display scan, checked every cycle against a behavioural model.
module tb_maze_engine;
    localparam int         ROOMS = 3;
    localparam int         SCAN  = 4;
    localparam int         TO    = 10;
    localparam logic [1:0] ACT   = 2'b10;

    logic       clk, rst, bl, bc, br;
    logic [1:0] ms;
    logic [3:0] seg, room_o;
    logic [7:0] hex;
    logic       done;

    maze_engine #(.ROOMS(ROOMS), .PATH(30'b10_01_00), .ACTIVE_STATE(ACT),
                  .SCAN_DIV(SCAN), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(clk), .RESET(rst), .BTNL(bl), .BTNC(bc), .BTNR(br),
        .MASTER_STATE(ms), .SEG_SELECT(seg), .HEX_OUT(hex),
        .MazeSM_OUT(room_o), .MAZE_DONE(done));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int ncmp = 0;
    int nfail = 0;

    // Model state: room, win flag, fail count, sampled button levels (index = button code).
    int       m_room, m_fail, cyc, m_idle;
    bit       m_win, m_done, m_act, m_act_prev;
    bit [2:0] s_cur, s_prev;
    int       path_code [3] = '{0, 1, 2};
    logic [7:0] font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_fail_event();
        m_room = 0;
        if (m_fail < 255) m_fail++;
    endtask

    task automatic tick();
        bit [2:0] rise;
        int nr, code, digit, v;
`ifdef MAZE_TIMEOUT_EN
        bit idle_cond;
`endif
        @(posedge clk);
        if (rst) begin
            m_room = 0; m_win = 0; m_fail = 0; m_done = 0; m_act = 0;
            m_act_prev = 0; s_cur = 0; s_prev = 0; cyc = 0; m_idle = 0;
        end else begin
            m_act  = (ms == ACT);
            rise   = s_cur & ~s_prev;
            nr     = $countones(rise);
            code   = rise[0] ? 0 : (rise[1] ? 1 : 2);
            m_done = 0;
`ifdef MAZE_TIMEOUT_EN
            idle_cond = m_act && !m_win && m_room > 0 && nr == 0;
`endif
            if (m_act) begin
                if (m_win) begin
                    if (!m_act_prev) begin m_win = 0; m_room = 0; end
                end else if (nr == 1 && path_code[m_room] == code) begin
                    if (m_room == ROOMS - 1) begin m_win = 1; m_done = 1; end
                    else m_room++;
                end else if (nr > 0) begin
                    m_fail_event();
                end
            end
`ifdef MAZE_TIMEOUT_EN
            m_idle = idle_cond ? m_idle + 1 : 0;
            if (m_idle == TO) begin m_fail_event(); m_idle = 0; end
`endif
            m_act_prev = m_act;
            s_prev = s_cur;
            s_cur  = {br, bc, bl};
            cyc++;
        end
        #1;
        digit = (cyc / SCAN) % 4;
        case (digit)
            0: v = m_win ? 15 : m_room;
            1: v = m_fail % 16;
            2: v = m_fail / 16;
            default: v = m_win ? 15 : (m_act ? 10 : 0);
        endcase
        chk("room_out", {4'h0, room_o}, m_win ? 8'h0F : 8'(m_room));
        chk("maze_done", {7'h0, done}, {7'h0, m_done});
        chk("seg_select", {4'h0, seg}, {4'h0, ~(4'b0001 << digit)});
        chk("hex_out", hex, font[v]);
    endtask

    task automatic set_btns(input bit [2:0] v);
        bl = v[0]; bc = v[1]; br = v[2];
    endtask

    task automatic press(input int b);
        set_btns(3'b001 << b); tick();
        set_btns(3'b000);      tick();
        tick();
    endtask

    task automatic reset_dut();
        rst = 1'b1; tick(); tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ms = ACT; set_btns(3'b000);
        tick(); tick();
        chk("rst_seg", {4'h0, seg}, 8'h0E);
        chk("rst_hex", hex, 8'hC0);
        chk("rst_room", {4'h0, room_o}, 8'h00);
        chk("rst_done", {7'h0, done}, 8'h00);
        rst = 1'b0;

        // Solve the maze: L, C, R.
        press(0); chk("room1", {4'h0, room_o}, 8'h01);
        press(1); chk("room2", {4'h0, room_o}, 8'h02);
        set_btns(3'b100); tick();
        set_btns(3'b000); tick();
        chk("done_pulse", {7'h0, done}, 8'h01);
        chk("won_room", {4'h0, room_o}, 8'h0F);
        tick();
        chk("done_once", {7'h0, done}, 8'h00);

        // Wrong press in room 2, then saturate the fail count.
        reset_dut();
        press(0); press(1); press(0);
        chk("wrong_room0", {4'h0, room_o}, 8'h00);
        repeat (300) press(1);
        for (int i = 0; i < 20 && seg != 4'b1011; i++) tick();
        chk("dig2_seg", {4'h0, seg}, 8'h0B);
        chk("dig2_ff", hex, 8'h8E);
        for (int i = 0; i < 20 && seg != 4'b1101; i++) tick();
        chk("dig1_seg", {4'h0, seg}, 8'h0D);
        chk("dig1_ff", hex, 8'h8E);

        // Two buttons in the same cycle, then a long hold.
        reset_dut();
        press(0);
        set_btns(3'b101); tick();
        set_btns(3'b000); tick(); tick();
        chk("dual_room0", {4'h0, room_o}, 8'h00);
        set_btns(3'b010);
        repeat (100) tick();
        set_btns(3'b000); tick(); tick();
        chk("hold_room0", {4'h0, room_o}, 8'h00);

        // Leave and re-enter mid-game, then after a win.
        reset_dut();
        press(0); press(1);
        ms = 2'b00;
        press(0); press(2); press(1);
        ms = ACT; tick();
        chk("resume_room2", {4'h0, room_o}, 8'h02);
        press(2);
        chk("win_again", {4'h0, room_o}, 8'h0F);
        ms = 2'b01; tick(); tick();
        ms = ACT; tick();
        chk("reenter_room0", {4'h0, room_o}, 8'h00);

        // Edge landing on the cycle the maze goes inactive is discarded.
        set_btns(3'b001); tick();
        ms = 2'b11; set_btns(3'b000); tick();
        ms = ACT; tick(); tick();
        chk("edge_dropped", {4'h0, room_o}, 8'h00);

`ifdef MAZE_TIMEOUT_EN
        reset_dut();
        press(0);
        repeat (12) tick();
        chk("timeout_room0", {4'h0, room_o}, 8'h00);
        press(0);
        repeat (5) tick();
        press(1);
        chk("no_timeout", {4'h0, room_o}, 8'h02);
`endif

        // Random play with occasional resets and master-state changes.
        reset_dut();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 31) == 0)
                ms = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : ACT;
            if ($urandom_range(0, 3) == 0) bl = ~bl;
            if ($urandom_range(0, 3) == 0) bc = ~bc;
            if ($urandom_range(0, 3) == 0) br = ~br;
            tick();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
